// File: rtl/demux1x8_32bit_reg.sv
// Registered 1-to-8 demultiplexer with a one-entry valid/ready holding register per lane.
// Optional macro DEMUX_ACCEPT_COUNT_EN adds a 16-bit wrapping count of accepted words.
module demux1x8_32bit_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   in,
    input  logic [2:0]         selection,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready
`ifdef DEMUX_ACCEPT_COUNT_EN
    ,
    output logic [15:0]        accept_count
`endif
);

    logic [WIDTH-1:0] data_r [8];
    logic [7:0]       valid_r;
    logic             accept_s;
    logic [7:0]       drain_s;

    // Handshake decode: a lane can take a word when empty or draining this cycle.
    always_comb begin
        in_ready = 1'b0;
        accept_s = 1'b0;
        drain_s  = 8'h00;
        in_ready = ~valid_r[selection] | out_ready[selection];
        accept_s = in_valid & in_ready;
        drain_s  = valid_r & out_ready;
    end

    // Lane holding registers; an accept wins over a drain so a lane can reload every cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (accept_s && (selection == 3'(i))) begin
                    data_r[i]  <= in;
                    valid_r[i] <= 1'b1;
                end else if (drain_s[i]) begin
                    data_r[i]  <= data_r[i];
                    valid_r[i] <= 1'b0;
                end else begin
                    data_r[i]  <= data_r[i];
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Pack lane registers onto the flat output bus.
    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            out[i*WIDTH +: WIDTH] = data_r[i];
        end
    end

    assign out_valid = valid_r;

`ifdef DEMUX_ACCEPT_COUNT_EN
    logic [15:0] count_r;

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= 16'h0000;
        end else if (accept_s) begin
            count_r <= count_r + 16'h0001;
        end else begin
            count_r <= count_r;
        end
    end

    assign accept_count = count_r;
`endif

endmodule

// File: tb/tb_demux1x8_32bit_reg.sv
// Self-checking bench for demux1x8_32bit_reg: per-lane queue model, directed cases, random traffic.
module tb_demux1x8_32bit_reg;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [W-1:0]   in;
    logic [2:0]     selection;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] out;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
`ifdef DEMUX_ACCEPT_COUNT_EN
    logic [15:0]    accept_count;
`endif

    int tests = 0;
    int fails = 0;

    demux1x8_32bit_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .selection (selection),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_ACCEPT_COUNT_EN
        ,
        .accept_count (accept_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: each lane is a queue of depth one plus the last word shown.
    logic [W-1:0] lane_q [8][$];
    logic [W-1:0] shown [8];
    logic [15:0]  model_count;
    bit           model_ok = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                lane_q[i].delete();
                shown[i] = '0;
            end
            model_count = 16'h0000;
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit take;
            int s;
            s = int'(selection);
            take = in_valid && ((lane_q[s].size() == 0) || out_ready[s]);
            for (int i = 0; i < 8; i++) begin
                if (lane_q[i].size() != 0 && out_ready[i]) void'(lane_q[i].pop_front());
            end
            if (take) begin
                lane_q[s].push_back(in);
                shown[s] = in;
                model_count = model_count + 16'd1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            logic [255:0] exp_out;
            logic [7:0]   exp_valid;
            logic         exp_ready;
            for (int i = 0; i < 8; i++) begin
                exp_out[i*W +: W] = shown[i];
                exp_valid[i] = (lane_q[i].size() != 0);
            end
            exp_ready = (lane_q[int'(selection)].size() == 0) || out_ready[selection];
            check("model_out", out, exp_out);
            check("model_out_valid", {248'd0, out_valid}, {248'd0, exp_valid});
            check("model_in_ready", {255'd0, in_ready}, {255'd0, exp_ready});
`ifdef DEMUX_ACCEPT_COUNT_EN
            check("model_accept_count", {240'd0, accept_count}, {240'd0, model_count});
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s, input logic [W-1:0] d);
        in_valid  = 1'b1;
        selection = s;
        in        = d;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        selection = 3'd3;
        in        = 32'hCAFEF00D;
        out_ready = 8'hFF;

        // Reset with a word on offer.
        cyc();
        cyc();
        check("reset_valid", {248'd0, out_valid}, 256'h0);
        check("reset_data", out, 256'h0);
`ifdef DEMUX_ACCEPT_COUNT_EN
        check("reset_count", {240'd0, accept_count}, 256'h0);
`endif
        reset_n  = 1'b1;
        in_valid = 1'b0;
        cyc();

        // Basic route to lane 5.
        out_ready = 8'hFF;
        send(3'd5, 32'hDEADBEEF);
        cyc();
        in_valid = 1'b0;
        check("route_valid", {248'd0, out_valid}, {248'd0, 8'h20});
        check("route_lane5", {224'd0, out[5*W +: W]}, {224'd0, 32'hDEADBEEF});
        cyc();
        check("route_drained", {248'd0, out_valid}, 256'h0);

        // Backpressure on lane 2 does not block lane 3.
        out_ready = 8'h00;
        send(3'd2, 32'h11111111);
        cyc();
        send(3'd2, 32'h22222222);
        #1;
        check("stall_in_ready", {255'd0, in_ready}, 256'h0);
        cyc();
        check("stall_lane2", {224'd0, out[2*W +: W]}, {224'd0, 32'h11111111});
        send(3'd3, 32'h33333333);
        #1;
        check("other_in_ready", {255'd0, in_ready}, 256'h1);
        cyc();
        in_valid = 1'b0;
        check("isolate_valid", {248'd0, out_valid}, {248'd0, 8'h0C});

        // Drain and reload of lane 7 in the same cycle.
        send(3'd7, 32'hA5A5A5A5);
        cyc();
        out_ready = 8'h80;
        send(3'd7, 32'h5A5A5A5A);
        #1;
        check("reload_in_ready", {255'd0, in_ready}, 256'h1);
        cyc();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        check("reload_valid", {248'd0, out_valid}, {248'd0, 8'h8C});
        check("reload_lane7", {224'd0, out[7*W +: W]}, {224'd0, 32'h5A5A5A5A});

        // Reset while lanes 0 and 4 are stalled.
        send(3'd0, 32'h0BADF00D);
        cyc();
        send(3'd4, 32'h44444444);
        cyc();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        cyc();
        check("midreset_valid", {248'd0, out_valid}, 256'h0);
        check("midreset_data", out, 256'h0);
        reset_n = 1'b1;
        send(3'd0, 32'h00000001);
        cyc();
        in_valid = 1'b0;
        check("post_reset_valid", {248'd0, out_valid}, {248'd0, 8'h01});
        check("post_reset_lane0", {224'd0, out[W-1:0]}, 256'h1);

        // Random traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            selection = 3'($urandom_range(0, 7));
            in        = $urandom;
            out_ready = 8'($urandom);
            cyc();
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        cyc();

`ifdef DEMUX_ACCEPT_COUNT_EN
        // Stream 65537 accepts so the counter wraps to one.
        reset_n = 1'b0;
        cyc();
        reset_n   = 1'b1;
        out_ready = 8'hFF;
        for (int k = 0; k < 65537; k++) begin
            send(3'(k), $urandom);
            #1;
            if (!in_ready) check("stream_in_ready", {255'd0, in_ready}, 256'h1);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check("count_wrap", {240'd0, accept_count}, {240'd0, 16'h0001});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux1x8_32bit_reg.md
Name: demux1x8_32bit_reg

Overview:
- Registered 1-to-8, 32-bit demultiplexer: the distributing counterpart of the 8-to-1 result-select mux.
- Takes one data word plus a 3-bit selection and delivers it to one of eight output lanes.
- Each lane has a one-entry holding register with a valid/ready handshake, so a slow consumer stalls only its own lane.
- Sits on the datapath wherever one producer (ALU result or write-back bus) must feed one of eight independent sinks.

Parameters:
- WIDTH, 32, data width of the input word and of each output lane.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in  input  WIDTH  data word to route.
- selection  input  3  destination lane index, 0..7; in1 maps to lane 0 in mux numbering.
- in_valid  input  1  producer offers in/selection this cycle.
- in_ready  output  1  block accepts the word this cycle.
- out  output  8*WIDTH  lane data; lane i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- out_valid  output  8  per-lane data valid.
- out_ready  input  8  per-lane consumer ready.

Behaviour:
- Reset (reset_n=0 at a clock edge): all out_valid=0 and all lane data=0. Reset overrides any in-flight accept or drain in the same cycle; words held in lanes are discarded.
- Per-lane state: data_q[i] (WIDTH bits) and valid_q[i]. out and out_valid come directly from these registers; no combinational path from in to out.
- in_ready is combinational: ~valid_q[selection] | out_ready[selection]. It depends on selection and on out_ready of the selected lane only.
- accept = in_valid & in_ready. in_valid=0 leaves all state unchanged apart from drains.
- Drain of lane i = valid_q[i] & out_ready[i].
- Lane update at each clock edge, for lane i:
  - Accept targets i: data_q[i] <= in, valid_q[i] <= 1. This covers the simultaneous drain-and-reload case, giving full throughput of 1 word/cycle per lane.
  - Otherwise, drain of i: valid_q[i] <= 0, data_q[i] holds its last value.
  - Otherwise: hold.
- Latency: a word accepted at edge N appears on out_valid/out of its lane after edge N, i.e. 1 cycle.
- Lanes are independent: a stalled lane (valid, not ready) never blocks accepts to other lanes. Multiple lanes may drain in the same cycle.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out lane i is held unchanged.
- out_ready on an invalid lane is ignored.
- Ordering: at most one word is accepted per cycle, so per-lane arrival order is preserved.
- selection is only meaningful when in_valid=1. in_ready may toggle with selection while in_valid=0, and this has no side effect.

Optional Feature:
- Macro DEMUX_ACCEPT_COUNT_EN.
- Defined:
  - Adds output port accept_count (16 bits), a count of accepted words.
  - Reset value 0; increments by 1 on each cycle with accept=1.
  - Wraps 16'hFFFF -> 16'h0000.
  - Registered, so it updates after the accepting edge.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=8'h00, all lane data 0, no accept recorded (accept_count=0 if enabled).
- Basic route: out_ready=8'hFF, send in=32'hDEADBEEF with selection=5 -> next cycle out_valid=8'h20 and lane 5 = 32'hDEADBEEF; cycle after, out_valid=8'h00.
- Backpressure/isolation: out_ready=8'h00; send 32'h11111111 to lane 2 (accepted). Then offer 32'h22222222 to lane 2 -> in_ready=0 and lane 2 keeps 32'h11111111. Then send 32'h33333333 to lane 3 -> accepted, out_valid=8'h0C.
- Drain-and-reload: lane 7 valid with 32'hA5A5A5A5 and out_ready[7]=1; send 32'h5A5A5A5A to lane 7 same cycle -> in_ready=1, next cycle out_valid[7]=1, lane 7 = 32'h5A5A5A5A.
- Reset mid-operation: lanes 0 and 4 valid and stalled, assert reset_n=0 for one edge -> out_valid=8'h00, lane data 0. First word after reset (32'h00000001 to lane 0) appears 1 cycle after accept.
- Counter wrap (DEMUX_ACCEPT_COUNT_EN): stream 65537 accepts round-robin over lanes 0..7 with out_ready=8'hFF -> accept_count reads 16'h0001; no cycle with in_valid=1 sees in_ready=0.
